// File: rtl/twd_pkg.sv
// Shared types and helpers for the trivial-twiddle FFT stage.
// Optional macro TWD_TRIV_SAT_EN selects a saturating negate.
package twd_pkg;

  typedef enum logic [1:0] {
    ROT_P1 = 2'd0,
    ROT_MJ = 2'd1,
    ROT_M1 = 2'd2,
    ROT_PJ = 2'd3
  } rot_e;

  localparam int NW = 32;
  typedef logic signed [NW-1:0] wide_t;

  // Encoding is the power of -j, so the forward
  // rotation is k and the inverse one is -k mod 4.
  function automatic rot_e rot_sel(
    input logic [1:0] k,
    input logic       mode
  );
    logic [1:0] q;
    q = mode ? (2'd0 - k) : k;
    return rot_e'(q);
  endfunction

  // Negate a sign-extended w-bit sample.
  // Result: {clipped, value}; caller keeps the low w bits.
  function automatic logic [NW:0] neg_w(
    input wide_t       x,
    input int unsigned w
  );
    wide_t lim;
    wide_t n;
    lim = wide_t'(1) <<< (w - 1);
    n   = -x;
`ifdef TWD_TRIV_SAT_EN
    if (n == lim) return {1'b1, lim - wide_t'(1)};
`endif
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/twd_rot_lane.sv
// One lane of trivial rotation by 1, -j, -1 or +j.
// In: i_rot, i_re, i_im. Out: o_re, o_im, o_sat.
module twd_rot_lane
  import twd_pkg::*;
#(
  parameter int DW = 10
) (
  input  rot_e                 i_rot,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic signed [DW-1:0] o_re,
  output logic signed [DW-1:0] o_im,
  output logic                 o_sat
);

  logic [NW:0] w_nre;
  logic [NW:0] w_nim;

  assign w_nre = neg_w(wide_t'(i_re), DW);
  assign w_nim = neg_w(wide_t'(i_im), DW);

  // Upper bits are just sign extension.
  logic w_unused;
  assign w_unused = ^{w_nre[NW-1:DW], w_nim[NW-1:DW]};

  always_comb begin
    o_re  = i_re;
    o_im  = i_im;
    o_sat = 1'b0;
    unique case (i_rot)
      ROT_P1: ;
      ROT_MJ: begin
        o_re  = i_im;
        o_im  = w_nre[DW-1:0];
        o_sat = w_nre[NW];
      end
      ROT_M1: begin
        o_re  = w_nre[DW-1:0];
        o_im  = w_nim[DW-1:0];
        o_sat = w_nre[NW] | w_nim[NW];
      end
      ROT_PJ: begin
        o_re  = w_nim[DW-1:0];
        o_im  = i_re;
        o_sat = w_nim[NW];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/twd_mul_triv.sv
// Trivial-twiddle stage: sums pass, diffs rotated per segment.
// Ports: clk, rstn, i_valid/i_clr/i_inv, sum/diff in, o_* out.
// TWD_TRIV_SAT_EN enables clipping and o_sat.
module twd_mul_triv
  import twd_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int DW      = 10,
  parameter int SEG_LEN = 8,
  parameter int N_SEG   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  input  logic                  i_clr,
  input  logic                  i_inv,
  input  logic [LANES*DW-1:0]   i_sum_re,
  input  logic [LANES*DW-1:0]   i_sum_im,
  input  logic [LANES*DW-1:0]   i_diff_re,
  input  logic [LANES*DW-1:0]   i_diff_im,
  output logic                  o_valid,
  output logic [LANES*DW-1:0]   o_sum_re,
  output logic [LANES*DW-1:0]   o_sum_im,
  output logic [LANES*DW-1:0]   o_diff_re,
  output logic [LANES*DW-1:0]   o_diff_im,
  output logic                  o_sat
);

  localparam int FRAME = N_SEG * SEG_LEN;
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int SH    = $clog2(SEG_LEN);
  localparam int LW    = LANES * DW;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [CW-1:0]    r_cnt;
  logic             r_inv;
  logic             r_vld;
  logic             r_sat;
  logic [LW-1:0]    r_sre;
  logic [LW-1:0]    r_sim;
  logic [LW-1:0]    r_dre;
  logic [LW-1:0]    r_dim;

  logic [CW-1:0]    w_ecnt;
  logic [CW-1:0]    w_nxt;
  logic [1:0]       w_k;
  logic             w_first;
  logic             w_mode;
  rot_e             w_rot;
  logic [LW-1:0]    w_dre;
  logic [LW-1:0]    w_dim;
  logic [LANES-1:0] w_lsat;

  // i_clr forces this beat to be frame beat 0.
  assign w_ecnt  = i_clr ? '0 : r_cnt;
  assign w_first = (w_ecnt == '0);
  assign w_k     = 2'(w_ecnt >> SH);
  assign w_nxt   = (w_ecnt == LAST) ? '0
                 : w_ecnt + CW'(1);
  assign w_mode  = w_first ? i_inv : r_inv;
  assign w_rot   = rot_sel(w_k, w_mode);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    twd_rot_lane #(
      .DW (DW)
    ) u_lane (
      .i_rot (w_rot),
      .i_re  (i_diff_re[g*DW +: DW]),
      .i_im  (i_diff_im[g*DW +: DW]),
      .o_re  (w_dre[g*DW +: DW]),
      .o_im  (w_dim[g*DW +: DW]),
      .o_sat (w_lsat[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_inv <= 1'b0;
      r_vld <= 1'b0;
      r_sat <= 1'b0;
      r_sre <= '0;
      r_sim <= '0;
      r_dre <= '0;
      r_dim <= '0;
    end else begin
      r_vld <= i_valid;
      r_sat <= i_valid & (|w_lsat);
      if (i_valid) begin
        r_cnt <= w_nxt;
        if (w_first) r_inv <= i_inv;
        r_sre <= i_sum_re;
        r_sim <= i_sum_im;
        r_dre <= w_dre;
        r_dim <= w_dim;
      end else if (i_clr) begin
        r_cnt <= '0;
      end
    end
  end

  assign o_valid   = r_vld;
  assign o_sat     = r_sat;
  assign o_sum_re  = r_sre;
  assign o_sum_im  = r_sim;
  assign o_diff_re = r_dre;
  assign o_diff_im = r_dim;

endmodule

// File: tb/tb_twd_mul_triv.sv
// Bench for twd_mul_triv: default instance A and a
// 4-segment instance B, driven with the same inputs.
module tb_twd_mul_triv;

  localparam int L    = 16;
  localparam int W    = 10;
  localparam int LW   = L * W;
  localparam int MINV = -(1 << (W - 1));
`ifdef TWD_TRIV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [LW-1:0] bus_t;
  typedef struct {
    bus_t sre;
    bus_t sim;
    bus_t dre;
    bus_t dim;
    logic sat;
  } exp_t;
  typedef struct {
    bit v;
    bit clr;
    bit inv;
    int re;
    int im;
    int ere;
    int eim;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic i_valid = 1'b0;
  logic i_clr   = 1'b0;
  logic i_inv   = 1'b0;
  bus_t i_sum_re  = '0;
  bus_t i_sum_im  = '0;
  bus_t i_diff_re = '0;
  bus_t i_diff_im = '0;

  logic a_valid, a_sat, b_valid, b_sat;
  bus_t a_sre, a_sim, a_dre, a_dim;
  bus_t b_sre, b_sim, b_dre, b_dim;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   m_cnt[2];
  bit   m_inv[2];
  exp_t hold[2];
  exp_t qa[$];
  exp_t qb[$];
  bit   last_v = 1'b0;
  vec_t tab[$];

  always #5 clk = ~clk;

  twd_mul_triv u_a (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_valid),
    .i_clr     (i_clr),
    .i_inv     (i_inv),
    .i_sum_re  (i_sum_re),
    .i_sum_im  (i_sum_im),
    .i_diff_re (i_diff_re),
    .i_diff_im (i_diff_im),
    .o_valid   (a_valid),
    .o_sum_re  (a_sre),
    .o_sum_im  (a_sim),
    .o_diff_re (a_dre),
    .o_diff_im (a_dim),
    .o_sat     (a_sat)
  );

  twd_mul_triv #(
    .LANES   (L),
    .DW      (W),
    .SEG_LEN (2),
    .N_SEG   (4)
  ) u_b (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_valid),
    .i_clr     (i_clr),
    .i_inv     (i_inv),
    .i_sum_re  (i_sum_re),
    .i_sum_im  (i_sum_im),
    .i_diff_re (i_diff_re),
    .i_diff_im (i_diff_im),
    .o_valid   (b_valid),
    .o_sum_re  (b_sre),
    .o_sum_im  (b_sim),
    .o_diff_re (b_dre),
    .o_diff_im (b_dim),
    .o_sat     (b_sat)
  );

  function automatic int seg_of(int d);
    return (d == 1) ? 2 : 8;
  endfunction

  function automatic int frm_of(int d);
    return (d == 1) ? 8 : 16;
  endfunction

  function automatic int sx(logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  // Negating the most negative value overflows.
  function automatic int fix(int x);
    if (x == -MINV) return SAT_EN ? (-MINV - 1) : MINV;
    return x;
  endfunction

  function automatic bus_t rbus();
    bus_t b;
    for (int i = 0; i < LW; i += 32) b[i +: 32] = $urandom();
    return b;
  endfunction

  function automatic bus_t ubus(int x);
    bus_t b;
    for (int l = 0; l < L; l++) b[l*W +: W] = W'(x);
    return b;
  endfunction

  function automatic bus_t rdiff();
    bus_t b;
    for (int l = 0; l < L; l++)
      b[l*W +: W] = ($urandom_range(0, 5) == 0) ? W'(MINV) : W'($urandom());
    return b;
  endfunction

  function automatic exp_t zexp();
    exp_t z;
    z.sre = '0;
    z.sim = '0;
    z.dre = '0;
    z.dim = '0;
    z.sat = 1'b0;
    return z;
  endfunction

  function automatic void add(bit v, bit c, bit inv, int re, int im, int ere, int eim);
    vec_t t;
    t.v = v; t.clr = c; t.inv = inv;
    t.re = re; t.im = im; t.ere = ere; t.eim = eim;
    tab.push_back(t);
  endfunction

  task automatic model(input int d, output exp_t e);
    int ec, k, idx, re, im, yr, yi;
    bit md, s;
    s  = 1'b0;
    ec = i_clr ? 0 : m_cnt[d];
    k  = ec / seg_of(d);
    md = (ec == 0) ? i_inv : m_inv[d];
    if (ec == 0) m_inv[d] = i_inv;
    idx = md ? (4 - k) % 4 : k;
    for (int l = 0; l < L; l++) begin
      re = sx(i_diff_re[l*W +: W]);
      im = sx(i_diff_im[l*W +: W]);
      case (idx)
        0: begin yr = re; yi = im; end
        1: begin yr = im; yi = -re; s |= (re == MINV); end
        2: begin yr = -re; yi = -im; s |= (re == MINV) || (im == MINV); end
        default: begin yr = -im; yi = re; s |= (im == MINV); end
      endcase
      e.dre[l*W +: W] = W'(fix(yr));
      e.dim[l*W +: W] = W'(fix(yi));
    end
    e.sre = i_sum_re;
    e.sim = i_sum_im;
    e.sat = s & SAT_EN;
    m_cnt[d] = (ec + 1) % frm_of(d);
  endtask

  task automatic chk(string nm, bus_t a, bus_t x);
    n_tot++;
    if (a === x) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, x);
  endtask

  task automatic chkb(string nm, logic a, logic x);
    n_tot++;
    if (a === x) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, a, x);
  endtask

  task automatic check_dut(
    input int d, input logic ov,
    input bus_t sre, input bus_t sim,
    input bus_t dre, input bus_t dim,
    input logic sat
  );
    exp_t  e;
    string p;
    p = (d == 1) ? "B" : "A";
    chkb({p, ".valid"}, ov, last_v);
    if (last_v) begin
      if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
        n_tot++;
        $display("FAIL %s.queue: got empty want entry", p);
        return;
      end
      e = (d == 1) ? qb.pop_front() : qa.pop_front();
      hold[d] = e;
    end else begin
      e = hold[d];
      e.sat = 1'b0;
    end
    chk({p, ".sum_re"}, sre, e.sre);
    chk({p, ".sum_im"}, sim, e.sim);
    chk({p, ".diff_re"}, dre, e.dre);
    chk({p, ".diff_im"}, dim, e.dim);
    chkb({p, ".sat"}, sat, e.sat);
  endtask

  task automatic check_all();
    check_dut(0, a_valid, a_sre, a_sim, a_dre, a_dim, a_sat);
    check_dut(1, b_valid, b_sre, b_sim, b_dre, b_dim, b_sat);
  endtask

  task automatic cyc(
    input bit v, input bit c, input bit inv,
    input bus_t dre, input bus_t dim,
    input bit tab_en, input int ere, input int eim, input bit esat
  );
    exp_t ea, eb;
    @(negedge clk);
    check_all();
    last_v    = v;
    i_valid   = v;
    i_clr     = c;
    i_inv     = inv;
    i_sum_re  = rbus();
    i_sum_im  = rbus();
    i_diff_re = dre;
    i_diff_im = dim;
    if (v) begin
      model(0, ea);
      if (tab_en) begin
        ea.dre = ubus(ere);
        ea.dim = ubus(eim);
        ea.sat = esat;
      end
      qa.push_back(ea);
      model(1, eb);
      qb.push_back(eb);
    end else if (c) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chkb("rst.A.valid", a_valid, 1'b0);
    chkb("rst.A.sat", a_sat, 1'b0);
    chk("rst.A.sum_re", a_sre, '0);
    chk("rst.A.sum_im", a_sim, '0);
    chk("rst.A.diff_re", a_dre, '0);
    chk("rst.A.diff_im", a_dim, '0);
    chkb("rst.B.valid", b_valid, 1'b0);
    chk("rst.B.diff_re", b_dre, '0);
    chk("rst.B.diff_im", b_dim, '0);
    i_valid = 1'b0;
    i_clr   = 1'b0;
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      hold[d]  = zexp();
      m_cnt[d] = 0;
      m_inv[d] = 1'b0;
    end
    last_v = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hold[d]  = zexp();
      m_cnt[d] = 0;
      m_inv[d] = 1'b0;
    end

    // Forward frame, then inv raised only for beats 0-4.
    for (int b = 0; b < 16; b++)
      add(1, 0, 0, 100, 50, b < 8 ? 100 : 50, b < 8 ? 50 : -100);
    for (int b = 0; b < 16; b++)
      add(1, 0, b < 5, 100, 50, b < 8 ? 100 : -50, b < 8 ? 50 : 100);
    for (int b = 0; b < 16; b++)
      add(1, 0, 0, 100, 50, b < 8 ? 100 : 50, b < 8 ? 50 : -100);
    // Inverse then forward on (3, 7); B steps every 2 beats.
    for (int b = 0; b < 16; b++)
      add(1, 0, b < 8, 3, 7, b < 8 ? 3 : -7, b < 8 ? 7 : 3);
    // Clear with a valid beat at beat 11, loading inverse mode.
    for (int b = 0; b < 11; b++)
      add(1, 0, 0, 100, 50, b < 8 ? 100 : 50, b < 8 ? 50 : -100);
    add(1, 1, 1, 100, 50, 100, 50);
    for (int b = 0; b < 7; b++) add(1, 0, 0, 100, 50, 100, 50);
    for (int b = 0; b < 8; b++) add(1, 0, 0, 100, 50, -50, 100);
    // Clear with no valid beat, mid-frame.
    for (int b = 0; b < 3; b++) add(1, 0, 0, 100, 50, 100, 50);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 8; b++) add(1, 0, 0, 100, 50, 100, 50);
    for (int b = 0; b < 8; b++) add(1, 0, 0, 100, 50, 50, -100);

    repeat (2) @(negedge clk);
    rstn = 1'b1;

    foreach (tab[i])
      cyc(tab[i].v, tab[i].clr, tab[i].inv,
          ubus(tab[i].re), ubus(tab[i].im),
          1'b1, tab[i].ere, tab[i].eim, 1'b0);

    // Sparse valid: one beat in three.
    for (int b = 0; b < 20; b++) begin
      cyc(1, 0, 1'($urandom_range(0, 1)), rdiff(), rdiff(), 0, 0, 0, 0);
      repeat (2) cyc(0, 0, 1'($urandom_range(0, 1)), rdiff(), rdiff(), 0, 0, 0, 0);
    end

    // Reset mid-frame, then the most negative value at k=1.
    for (int b = 0; b < 9; b++) cyc(1, 0, 0, rdiff(), rdiff(), 0, 0, 0, 0);
    do_reset();
    for (int b = 0; b < 8; b++) cyc(1, 0, 0, rdiff(), rdiff(), 0, 0, 0, 0);
    cyc(1, 0, 0, ubus(MINV), ubus(0), 1, 0,
        SAT_EN ? (-MINV - 1) : MINV, SAT_EN);

    // Random traffic with occasional clears.
    for (int b = 0; b < 80; b++)
      cyc(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)), rdiff(), rdiff(), 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, '0, '0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/twd_mul_triv.md
# twd_mul_triv

Parametrised trivial-twiddle stage for the pipelined FFT. It sits after a radix-2 butterfly bank. Every valid beat, it passes the butterfly sum lanes through unchanged. It rotates the difference lanes by a twiddle from {1, −j, −1, +j}, chosen per segment of a frame by an internal beat counter. The block adds a forward/inverse mode, a configurable segment count and length, and a registered valid output.

## Interface
- LANES, 16, parallel butterfly lanes per beat
- DW, 10, signed sample width in bits, re and im each
- SEG_LEN, 8, beats per twiddle segment; power of two, ≥1
- N_SEG, 2, segments per frame; one of 1, 2, 4
- clk  in  1  clock
- rstn  in  1  reset; one clock, asynchronous active-low reset
- i_valid  in  1  input beat valid
- i_clr  in  1  synchronous frame restart
- i_inv  in  1  inverse-FFT mode; sampled at frame start
- i_sum_re, i_sum_im  in  LANES×DW signed  butterfly sum
- i_diff_re, i_diff_im  in  LANES×DW signed  butterfly difference
- o_valid  out  1  output beat valid
- o_sum_re, o_sum_im  out  LANES×DW signed  sum, passed through
- o_diff_re, o_diff_im  out  LANES×DW signed  rotated difference
- o_sat  out  1  a negation clipped in this output beat

## Operation
- Beat counter `cnt`, width clog2(N_SEG·SEG_LEN), minimum 1.
  - Increments on each accepted beat.
  - Wraps from N_SEG·SEG_LEN−1 to 0.
- Effective count for the current beat: `ecnt` = 0 if i_clr, else `cnt`.
- Segment index: `k` = ecnt / SEG_LEN.
- Counter update on an i_valid beat: cnt ← ecnt+1 (with wrap).
- i_clr without i_valid: cnt ← 0.
- Mode register `inv_q`:
  - Loaded from i_inv on a valid beat with ecnt==0.
  - Frame's first beat: `mode` = i_inv. Other beats: `mode` = inv_q.
  - i_inv changes mid-frame are ignored until the next frame start.
- Rotation `r`:
  - Forward (mode=0): r = (−j)^k.
  - Inverse (mode=1): r = (+j)^k.
  - With N_SEG=1, r = 1 always.
- Per lane, for the difference path:
  - r=1: (re, im)
  - r=−j: (im, −re)
  - r=−1: (−re, −im)
  - r=+j: (−im, re)
- Sum lanes are never modified.
- Negation is DW-bit two's complement. The single overflow case is negating −2^(DW−1); its handling is set under Configuration.
- No multipliers or growth bits; output width equals input width.
- Without i_valid, the counter, inv_q and all data outputs hold.

## Timing
- Latency: 1 cycle. A beat at edge n appears on the outputs after edge n, with o_valid=1 for that cycle.
- o_valid is i_valid delayed by one register. No backpressure; every i_valid beat is accepted.
- Data outputs update only on i_valid and hold otherwise. o_sat updates on every edge: 0 when there is no valid beat.
- Reset (rstn low, any time, including mid-frame):
  - cnt=0, inv_q=0, o_valid=0, o_sat=0, all data outputs 0.
  - The first beat after reset is segment 0 of a new frame.
- i_clr and i_valid in the same cycle:
  - The beat is processed as segment 0 and sets inv_q.
  - cnt becomes 1 (0 if N_SEG·SEG_LEN=1).
- Back-to-back frames with no gap: the beat after wrap uses segment 0 and re-samples i_inv.

## Configuration
- TWD_TRIV_SAT_EN defined:
  - Negating −2^(DW−1) yields +2^(DW−1)−1.
  - o_sat pulses for that output beat when any lane of the difference path clipped.
- Undefined:
  - Negation wraps, so −2^(DW−1) stays −2^(DW−1).
  - o_sat is tied to 0.

## Structure
- Shared package `twd_pkg`:
  - rotation enum `rot_e` (ROT_P1, ROT_MJ, ROT_M1, ROT_PJ).
  - function mapping (k, mode) → rot_e.
  - saturating/wrapping negate function, guarded by the macro.
- Sub-module `twd_rot_lane`: combinational single-lane rotation (rot_e, re, im → re, im, sat), instantiated LANES times. Registers, counter and mode logic stay in the top.

## Test plan
- Forward, defaults; 16 beats with diff=(100, 50) on all lanes.
  - Beats 0–7 output (100, 50). Beats 8–15 output (50, −100).
  - Sum equals input; o_valid lags i_valid by 1.
- N_SEG=4, SEG_LEN=2, inverse; i_inv=1 at beat 0, diff=(3, 7).
  - Pairs output (3, 7), (−7, 3), (−3, −7), (7, −3).
  - Repeat forward: (3, 7), (7, −3), (−3, −7), (−7, 3).
- Toggle i_inv at beat 5 of a frame: rotations unchanged until the next frame; the new mode is applied from beat 16.
- Sparse i_valid (1 of 3 cycles) across 20 beats: the counter advances only on valid beats, and outputs hold between them.
- i_clr at beat 11 together with i_valid: that beat gets r=1. Beats from that point follow segment 0 for 7 beats, then segment 1.
- Assert rstn at beat 9: all outputs are 0 at once. After release, diff=(−512, 0) at k=1, DW=10:
  - With TWD_TRIV_SAT_EN: output (0, 511), o_sat=1.
  - Without: output (0, −512), o_sat=0.
